// File: rtl/fpu_addcmp_unit.sv
// Single-precision add/sub, min/max, compare and sign-op unit.
// Fixed four-edge latency from accept to result.
module fpu_addcmp_unit #(
   parameter bit          LATENCY_CHECK = 1'b1,
   parameter logic [31:0] CANON_NAN     = 32'h7FC00000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] fpu1in,
   input  logic [31:0] fpu2in,
   input  logic [4:0]  fpuen,
   output logic [31:0] fpuout,
   output logic        fpudone,
   output logic        fpubusy
);
   typedef enum logic [2:0] {StIdle, StAlign, StAddSub, StNorm, StDone} state_e;

   localparam logic [3:0] OpAdd = 4'd0, OpSub = 4'd1, OpMin = 4'd2, OpMax = 4'd3, OpEq = 4'd4,
                          OpLt = 4'd5, OpLe = 4'd6, OpNeg = 4'd7, OpAbs = 4'd8, OpSgnj = 4'd9;

   state_e      state_q, state_d;
   logic [31:0] a_q, b_q, spec_res_q, res_q;
   logic [3:0]  op_q;
   logic        spec_q, sign_q, zsign_q, sub_q;
   logic [7:0]  exp_q;
   logic [26:0] siga_q, sigb_q;
   logic [27:0] sum_q;

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      lzc27 = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (v[i]) lzc27 = 5'(26 - i);
      end
   endfunction

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (fpuen[4]) state_d = StAlign;
         StAlign:  state_d = StAddSub;
         StAddSub: state_d = StNorm;
         StNorm:   state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // ALIGN stage: flush, classify, order, shift, and resolve all non-add results
   logic [31:0] fa, fb, fbe, big, sml, spec_res_d;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sb_eff, a_big;
   logic        tot_lt, cmp_lt, cmp_eq, spec_d;
   logic [7:0]  diff;
   logic [26:0] sig_s, sig_s_sh;

   always_comb begin
      fa     = (a_q[30:23] == 8'h00) ? {a_q[31], 31'b0} : a_q;
      fb     = (b_q[30:23] == 8'h00) ? {b_q[31], 31'b0} : b_q;
      a_nan  = (&fa[30:23]) && (|fa[22:0]);
      b_nan  = (&fb[30:23]) && (|fb[22:0]);
      a_inf  = (&fa[30:23]) && !(|fa[22:0]);
      b_inf  = (&fb[30:23]) && !(|fb[22:0]);
      a_zero = (fa[30:23] == 8'h00);
      b_zero = (fb[30:23] == 8'h00);
      sb_eff = fb[31] ^ (op_q == OpSub);
      fbe    = {sb_eff, fb[30:0]};
      a_big  = (fa[30:0] >= fb[30:0]);
      big    = a_big ? fa : fbe;
      sml    = a_big ? fbe : fa;
      diff   = big[30:23] - sml[30:23];
      sig_s  = {|sml[30:23], sml[22:0], 3'b000};
      if (diff >= 8'd26) begin
         sig_s_sh = {26'b0, |sig_s};
      end else begin
         sig_s_sh = (sig_s >> diff) | {26'b0, |(sig_s & ((27'd1 << diff) - 27'd1))};
      end

      // Total order with -0 below +0; compares treat the zeros as equal
      if (fa[31] != fb[31])  tot_lt = fa[31];
      else if (!fa[31])      tot_lt = fa[30:0] < fb[30:0];
      else                   tot_lt = fb[30:0] < fa[30:0];
      cmp_lt = tot_lt && !(a_zero && b_zero);
      cmp_eq = (fa == fb) || (a_zero && b_zero);

      spec_d     = 1'b1;
      spec_res_d = 32'h0;
      unique case (op_q)
         OpAdd, OpSub: begin
            spec_d = a_nan || b_nan || a_inf || b_inf;
            if (a_nan || b_nan)     spec_res_d = CANON_NAN;
            else if (a_inf && b_inf) spec_res_d = (fa[31] == sb_eff) ? fa : CANON_NAN;
            else if (a_inf)          spec_res_d = fa;
            else                     spec_res_d = fbe;
         end
         OpMin, OpMax: begin
            if (a_nan && b_nan) spec_res_d = CANON_NAN;
            else if (a_nan)     spec_res_d = fb;
            else if (b_nan)     spec_res_d = fa;
            else                spec_res_d = (tot_lt ^ (op_q == OpMax)) ? fa : fb;
         end
         OpEq:    spec_res_d = {31'b0, !(a_nan || b_nan) && cmp_eq};
         OpLt:    spec_res_d = {31'b0, !(a_nan || b_nan) && cmp_lt};
         OpLe:    spec_res_d = {31'b0, !(a_nan || b_nan) && (cmp_lt || cmp_eq)};
         OpNeg:   spec_res_d = {~fa[31], fa[30:0]};
         OpAbs:   spec_res_d = {1'b0, fa[30:0]};
         OpSgnj:  spec_res_d = {fb[31], fa[30:0]};
         default: spec_res_d = 32'h0;
      endcase
   end

   // NORM stage
   logic [4:0]        lz;
   logic [26:0]       nsig;
   logic signed [9:0] nexp;
   logic [31:0]       norm_res;
   logic              unused_norm;

   always_comb begin
      lz = lzc27(sum_q[26:0]);
      if (sum_q[27]) begin
         nsig = {sum_q[27:2], sum_q[1] | sum_q[0]};
         nexp = $signed({2'b00, exp_q}) + 10'sd1;
      end else begin
         nsig = sum_q[26:0] << lz;
         nexp = $signed({2'b00, exp_q}) - $signed({5'b00000, lz});
      end
      if (sum_q == 28'd0)         norm_res = {zsign_q, 31'b0};
      else if (nexp >= 10'sd255)  norm_res = {sign_q, 8'hFF, 23'b0};
      else if (nexp <= 10'sd0)    norm_res = {sign_q, 31'b0};
      else                        norm_res = {sign_q, nexp[7:0], nsig[25:3]};
   end
   assign unused_norm = ^{nsig[26], nsig[2:0], nexp[9:8]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         sign_q     <= 1'b0;
         zsign_q    <= 1'b0;
         sub_q      <= 1'b0;
         exp_q      <= '0;
         siga_q     <= '0;
         sigb_q     <= '0;
         sum_q      <= '0;
         res_q      <= '0;
         fpuout     <= '0;
         fpudone    <= 1'b0;
      end else begin
         state_q <= state_d;
         fpudone <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (fpuen[4]) begin
                  a_q  <= fpu1in;
                  b_q  <= fpu2in;
                  op_q <= fpuen[3:0];
               end
            end
            StAlign: begin
               spec_q     <= spec_d;
               spec_res_q <= spec_res_d;
               sign_q     <= big[31];
               zsign_q    <= fa[31] & sb_eff;
               sub_q      <= fa[31] ^ sb_eff;
               exp_q      <= big[30:23];
               siga_q     <= {|big[30:23], big[22:0], 3'b000};
               sigb_q     <= sig_s_sh;
            end
            StAddSub: sum_q <= sub_q ? ({1'b0, siga_q} - {1'b0, sigb_q})
                                     : ({1'b0, siga_q} + {1'b0, sigb_q});
            StNorm:   res_q <= spec_q ? spec_res_q : norm_res;
            StDone: begin
               fpuout  <= res_q;
               fpudone <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign fpubusy = (state_q != StIdle) || fpudone;

   if (LATENCY_CHECK) begin : g_busy_check
      busy_cmd_a: assert property (@(posedge clk) disable iff (!reset)
                                   !(fpuen[4] && state_q != StIdle))
         else $warning("command dropped while unit busy");
   end

endmodule

// File: tb/tb_fpu_addcmp_unit.sv
// Randomized and directed checks of fpu_addcmp_unit against a value-level model.
module tb_fpu_addcmp_unit;
   localparam logic [31:0] CanonNan = 32'h7FC00000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fpu1in, fpu2in, fpuout;
   logic [4:0]  fpuen;
   logic        fpudone, fpubusy;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   fpu_addcmp_unit #(
      .LATENCY_CHECK(1'b0),
      .CANON_NAN    (CanonNan)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .fpu1in (fpu1in),
      .fpu2in (fpu2in),
      .fpuen  (fpuen),
      .fpuout (fpuout),
      .fpudone(fpudone),
      .fpubusy(fpubusy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] flush(input logic [31:0] x);
      return (x[30:23] == 8'h00) ? {x[31], 31'b0} : x;
   endfunction

   function automatic bit is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   function automatic bit is_inf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
   endfunction

   function automatic real to_real(input logic [31:0] x);
      real r;
      int  e;
      if (x[30:23] == 8'h00) return 0.0;
      e = int'(x[30:23]);
      r = $itor({8'd0, 1'b1, x[22:0]}) / 8388608.0;
      if (e >= 127) repeat (e - 127) r = r * 2.0;
      else          repeat (127 - e) r = r / 2.0;
      return x[31] ? -r : r;
   endfunction

   // Exact magnitude sum in a wide integer frame, then truncate to 24 bits
   function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b,
                                             input bit sub);
      logic [31:0]  fa, fb, big, sml;
      logic [127:0] m, msml;
      int           ebig, esml, d, sh, p, e_res;
      fa = flush(a);
      fb = flush(b);
      if (sub) fb[31] = ~fb[31];
      if (is_nan(fa) || is_nan(fb)) return CanonNan;
      if (is_inf(fa) && is_inf(fb)) return (fa[31] == fb[31]) ? fa : CanonNan;
      if (is_inf(fa)) return fa;
      if (is_inf(fb)) return fb;
      if (fa[30:0] >= fb[30:0]) begin big = fa; sml = fb; end
      else                      begin big = fb; sml = fa; end
      ebig = int'(big[30:23]);
      esml = int'(sml[30:23]);
      if (ebig == 0) return {fa[31] & fb[31], 31'b0};
      m    = {104'd0, 1'b1, big[22:0]};
      msml = (esml != 0) ? {104'd0, 1'b1, sml[22:0]} : 128'd0;
      d    = ebig - esml;
      sh   = (d > 60) ? 60 : d;
      m    = m << sh;
      if (msml != 0) begin
         if (d > 60) msml = 128'd1;
         if (big[31] == sml[31]) m = m + msml;
         else                    m = m - msml;
      end
      if (m == 0) return {fa[31] & fb[31], 31'b0};
      p = 127;
      while (!m[p]) p--;
      e_res = ebig - sh + p - 23;
      if (e_res >= 255) return {big[31], 8'hFF, 23'b0};
      if (e_res <= 0) return {big[31], 31'b0};
      if (p >= 23) m = m >> (p - 23);
      else         m = m << (23 - p);
      return {big[31], 8'(e_res), m[22:0]};
   endfunction

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] fa, fb;
      bit          anyn, a_lt;
      fa   = flush(a);
      fb   = flush(b);
      anyn = is_nan(fa) || is_nan(fb);
      case (op)
         4'd0: return model_add(a, b, 1'b0);
         4'd1: return model_add(a, b, 1'b1);
         4'd2, 4'd3: begin
            if (is_nan(fa) && is_nan(fb)) return CanonNan;
            if (is_nan(fa)) return fb;
            if (is_nan(fb)) return fa;
            if (fa[30:23] == 8'h00 && fb[30:23] == 8'h00) a_lt = fa[31] && !fb[31];
            else a_lt = to_real(fa) < to_real(fb);
            if (op == 4'd2) return a_lt ? fa : fb;
            return a_lt ? fb : fa;
         end
         4'd4: return {31'b0, !anyn && (to_real(fa) == to_real(fb))};
         4'd5: return {31'b0, !anyn && (to_real(fa) < to_real(fb))};
         4'd6: return {31'b0, !anyn && (to_real(fa) <= to_real(fb))};
         4'd7: return {~fa[31], fa[30:0]};
         4'd8: return {1'b0, fa[30:0]};
         4'd9: return {fb[31], fa[30:0]};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] pick_special();
      logic [31:0] sp[12];
      sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
             32'h7F800001, 32'h00000001, 32'h807FFFFF, 32'h3F800000, 32'h7F7FFFFF,
             32'hFF7FFFFF, 32'h00800000};
      return sp[$urandom_range(0, 11)];
   endfunction

   function automatic logic [31:0] rand_operand();
      int unsigned sel;
      sel = $urandom_range(0, 5);
      if (sel == 0) return pick_special();
      if (sel <= 3) return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      return $urandom;
   endfunction

   function automatic logic [31:0] rel_operand(input logic [31:0] a);
      int unsigned sel;
      int          e;
      sel = $urandom_range(0, 7);
      case (sel)
         0: return pick_special();
         1: return {~a[31], a[30:0]};
         2: return a ^ (32'd1 << $urandom_range(0, 4));
         3, 4, 5: begin
            e = int'(a[30:23]) + int'($urandom_range(0, 60)) - 30;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            return {1'($urandom), 8'(e), 23'($urandom)};
         end
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int early;
      fpu1in = a;
      fpu2in = b;
      fpuen  = {1'b1, op};
      tick();
      fpuen = '0;
      check({tag, "/busy"}, {31'b0, fpubusy}, 32'd1);
      early = 0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (fpudone) early++;
      end
      tick();
      check({tag, "/early_done"}, early, 32'd0);
      check({tag, "/done"}, {31'b0, fpudone}, 32'd1);
      check(tag, fpuout, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cnt;
      logic [3:0]  op;
      logic [31:0] a, b;

      reset  = 1'b0;
      fpu1in = '0;
      fpu2in = '0;
      fpuen  = '0;
      repeat (3) tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("rst/out", fpuout, 32'h0);
      check("rst/busy", {31'b0, fpubusy}, 32'd0);
      check("rst/done", {31'b0, fpudone}, 32'd0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (fpudone || fpubusy) cnt++;
      end
      check("idle/no_activity", cnt, 32'd0);

      run_op("add_1_2", 4'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
      run_op("sub_self", 4'd1, 32'h3F800000, 32'h3F800000, 32'h00000000);
      run_op("add_trunc", 4'd0, 32'h3F800000, 32'h33800000, 32'h3F800000);
      run_op("sub_trunc", 4'd1, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF);
      run_op("add_ovf", 4'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
      run_op("add_inf_ninf", 4'd0, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
      run_op("min_zeros", 4'd2, 32'h80000000, 32'h00000000, 32'h80000000);
      run_op("max_nan", 4'd3, 32'h7FC00000, 32'h40000000, 32'h40000000);
      run_op("feq_zeros", 4'd4, 32'h00000000, 32'h80000000, 32'h00000001);
      run_op("flt_nan", 4'd5, 32'h3F800000, 32'h7FC00000, 32'h00000000);
      run_op("add_nzeros", 4'd0, 32'h80000000, 32'h80000000, 32'h80000000);
      run_op("sgnj", 4'd9, 32'h3F800000, 32'hC0000000, 32'hBF800000);
      run_op("abs_nan", 4'd8, 32'hFFC00001, 32'h0, 32'h7FC00001);
      run_op("denorm_flush", 4'd0, 32'h00000001, 32'h80000002, 32'h00000000);
      run_op("op_unused", 4'd12, 32'h3F800000, 32'h3F800000, 32'h00000000);

      // Commands while busy are dropped
      fpu1in = 32'h3F800000;
      fpu2in = 32'h40000000;
      fpuen  = {1'b1, 4'd0};
      tick();
      fpu1in = 32'h40400000;
      fpu2in = 32'h3F800000;
      fpuen  = {1'b1, 4'd1};
      cnt = 0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (fpudone) cnt++;
      end
      fpuen = '0;
      tick();
      if (fpudone) cnt++;
      check("drop/out", fpuout, 32'h40400000);
      check("drop/one_done", cnt, 32'd1);
      fpuen = {1'b1, 4'd1};
      tick();
      fpuen = '0;
      cnt = 0;
      for (int i = 6; i <= 8; i++) begin
         tick();
         if (fpudone) cnt++;
      end
      tick();
      check("reissue/early_done", cnt, 32'd0);
      check("reissue/done", {31'b0, fpudone}, 32'd1);
      check("reissue/out", fpuout, 32'h40000000);

      // Reset in the middle of an operation aborts it
      fpu1in = 32'h3F800000;
      fpu2in = 32'h3F800000;
      fpuen  = {1'b1, 4'd0};
      tick();
      fpuen = '0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("midrst/out", fpuout, 32'h0);
      check("midrst/busy", {31'b0, fpubusy}, 32'd0);
      tick();
      @(negedge clk);
      reset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (fpudone) cnt++;
      end
      check("midrst/no_done", cnt, 32'd0);
      run_op("neg_after_rst", 4'd7, 32'h3F800000, 32'h0, 32'hBF800000);

      for (int n = 0; n < 300; n++) begin
         op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
         a  = rand_operand();
         b  = rel_operand(a);
         run_op($sformatf("rand%0d op%0d %08h %08h", n, op, a, b), op, a, b, model(op, a, b));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
